// File: rtl/fa_chk_pkg.sv
// Shared types and constants for the full-adder response checker.
// Holds the sweep FSM state encoding, vector/error widths and the saturating error increment.
package fa_chk_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;
  localparam int ERR_W       = 4;

  localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } chk_state_e;

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] cnt);
    return (cnt == ERR_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Golden full-adder: expected sum and carry for the vector currently being driven.
module fa_ref_model
  import fa_chk_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic exp_s,
  output logic exp_cout
);

  assign exp_s    = a ^ b ^ cin;
  assign exp_cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_resp_checker.sv
// Exhaustive full-adder sweep: drives all 8 {a,b,cin} vectors, holds each for SETTLE_CYCLES,
// samples the DUT once per vector and accumulates a saturating error count plus first-fail index.
module fa_resp_checker
  import fa_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       cin,
  input  logic       dut_s,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail_vec
);

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VECTORS - 1);

  chk_state_e       state_q;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] stim_q;
  logic [3:0]       cnt_q;
  logic [ERR_W-1:0] err_q;
  logic             fv_q;
  logic [VEC_W-1:0] ffv_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic             exp_s;
  logic             exp_cout;
  logic             mismatch;
  logic             stop;
  logic [ERR_W-1:0] err_d;
  logic             fv_d;
  logic [VEC_W-1:0] ffv_d;

  // Reference sees the registered stimulus, so expectations track exactly what the DUT sees.
  fa_ref_model u_ref (
    .a        (stim_q[2]),
    .b        (stim_q[1]),
    .cin      (stim_q[0]),
    .exp_s    (exp_s),
    .exp_cout (exp_cout)
  );

  assign mismatch = (dut_s ^ exp_s) | (dut_cout ^ exp_cout);
  assign stop     = (vec_q == LAST_VEC) || (mismatch && STOP_ON_FAIL);

  always_comb begin
    err_d = err_q;
    fv_d  = fv_q;
    ffv_d = ffv_q;
    if (mismatch) begin
      err_d = err_sat_inc(err_q);
      if (!fv_q) begin
        fv_d  = 1'b1;
        ffv_d = vec_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= DRIVE;
            vec_q   <= '0;
            stim_q  <= '0;
            cnt_q   <= SETTLE_LD;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffv_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        DRIVE: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == 4'd1) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_q <= err_d;
          fv_q  <= fv_d;
          ffv_q <= ffv_d;
          if (stop) begin
            state_q <= DONE;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= DRIVE;
            vec_q   <= vec_q + 1'b1;
            stim_q  <= vec_q + 1'b1;
            cnt_q   <= SETTLE_LD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a              = stim_q[2];
  assign b              = stim_q[1];
  assign cin            = stim_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_fa_resp_checker.sv
// Directed bench for fa_resp_checker: three instances (default, stop-on-fail, 3-cycle settle)
// each wired to a full-adder stand-in whose fault mode the sequence selects.
module tb_fa_resp_checker;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  logic [1:0] fault0, fault1, fault2;

  logic a0, b0, cin0, s0, c0, busy0, done0, pass0, fv0;
  logic a1, b1, cin1, s1, c1, busy1, done1, pass1, fv1;
  logic a2, b2, cin2, s2, c2, busy2, done2, pass2, fv2;
  logic [3:0] err0, err1, err2;
  logic [2:0] ffv0, ffv1, ffv2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Fault modes: 0 = correct adder, 1 = carry stuck at 0, 2 = sum inverted. Returns {cout, s}.
  function automatic logic [1:0] fa_resp(input logic [1:0] f, input logic a, input logic b, input logic c);
    logic s, co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    if (f == 2'd1) co = 1'b0;
    if (f == 2'd2) s = ~s;
    return {co, s};
  endfunction

  assign {c0, s0} = fa_resp(fault0, a0, b0, cin0);
  assign {c1, s1} = fa_resp(fault1, a1, b1, cin1);
  assign {c2, s2} = fa_resp(fault2, a2, b2, cin2);

  fa_resp_checker u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(cin0),
    .dut_s(s0), .dut_cout(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .first_fail_vec(ffv0)
  );

  fa_resp_checker #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .dut_s(s1), .dut_cout(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .first_fail_vec(ffv1)
  );

  fa_resp_checker #(.SETTLE_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .dut_s(s2), .dut_cout(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .first_fail_vec(ffv2)
  );

  // Status layout: {busy, done, pass, fail_valid, err_count[3:0], first_fail_vec[2:0], {a,b,cin}}
  logic [13:0] stat0, stat1, stat2;
  assign stat0 = {busy0, done0, pass0, fv0, err0, ffv0, a0, b0, cin0};
  assign stat1 = {busy1, done1, pass1, fv1, err1, ffv1, a1, b1, cin1};
  assign stat2 = {busy2, done2, pass2, fv2, err2, ffv2, a2, b2, cin2};

  function automatic logic [13:0] pk(input logic bz, input logic dn, input logic ps, input logic fv,
                                     input logic [3:0] err, input logic [2:0] ffv, input logic [2:0] abc);
    return {bz, dn, ps, fv, err, ffv, abc};
  endfunction

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed {busy,done,pass,fv,err,ffv,abc}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    fault0 = 2'd0; fault1 = 2'd0; fault2 = 2'd0;
    step(2);
    chk("reset_u0", stat0, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    chk("reset_u1", stat1, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    chk("reset_u2", stat2, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    rst = 1'b0;
    step(1);

    // Clean sweep, default settle
    start0 = 1'b1; step(1); start0 = 1'b0;
    chk("clean_e0", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    step(2);
    chk("clean_e2", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd1));
    step(2);
    chk("clean_e4", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd2));
    step(11);
    chk("clean_e15", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd7));
    step(1);
    chk("clean_e16", stat0, pk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0));
    step(3);
    chk("clean_hold", stat0, pk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0));

    // Carry stuck at 0: vectors 3,5,6,7 fail
    fault0 = 2'd1;
    start0 = 1'b1; step(1); start0 = 1'b0;
    chk("cs0_e0", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    step(7);
    chk("cs0_e7", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd3));
    step(1);
    chk("cs0_e8", stat0, pk(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 3'd3, 3'd4));
    step(8);
    chk("cs0_e16", stat0, pk(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 3'd3, 3'd0));

    // Start held high through a sweep; restart from DONE clears results
    fault0 = 2'd0;
    start0 = 1'b1; step(1);
    chk("held_e0", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    step(8);
    chk("held_e8", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd4));
    step(8);
    chk("held_e16", stat0, pk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0));
    step(1);
    chk("held_restart", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    start0 = 1'b0;
    step(15);
    chk("held2_e15", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd7));
    step(1);
    chk("held2_e16", stat0, pk(0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0));

    // Reset mid-sweep at vec_idx=4, with start also high on the reset edge
    fault0 = 2'd1;
    start0 = 1'b1; step(1); start0 = 1'b0;
    step(8);
    chk("mid_e8", stat0, pk(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 3'd3, 3'd4));
    rst = 1'b1; start0 = 1'b1;
    step(1);
    chk("mid_rst", stat0, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    rst = 1'b0; start0 = 1'b0;
    step(1);
    chk("mid_idle", stat0, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    fault0 = 2'd0;
    start0 = 1'b1; step(1); start0 = 1'b0;
    step(15);
    chk("post_rst_e15", stat0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd7));
    step(1);
    chk("post_rst_e16", stat0, pk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0));

    // Stop-on-fail with inverted sum: ends after vector 0
    fault1 = 2'd2;
    start1 = 1'b1; step(1); start1 = 1'b0;
    chk("sof_e0", stat1, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    step(1);
    chk("sof_e1", stat1, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    step(1);
    chk("sof_e2", stat1, pk(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 3'd0, 3'd0));
    step(2);
    chk("sof_hold", stat1, pk(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 3'd0, 3'd0));

    // Three-cycle settle, correct adder
    start2 = 1'b1; step(1); start2 = 1'b0;
    chk("s3_e0", stat2, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    step(3);
    chk("s3_e3", stat2, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0));
    step(1);
    chk("s3_e4", stat2, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd1));
    step(3);
    chk("s3_e7", stat2, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd1));
    step(24);
    chk("s3_e31", stat2, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd7));
    step(1);
    chk("s3_e32", stat2, pk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fa_resp_checker.md
FA_RESP_CHECKER -- requirements
Module: fa_resp_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, cycles each vector is held before sampling (legal range 1..15).
REQ-002 Parameter STOP_ON_FAIL, default 0, when 1 the sweep ends at the first mismatch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a sweep; sampled only in IDLE or DONE.
REQ-006 a, b, cin  output  1 each  stimulus driven to the full-adder DUT.
REQ-007 dut_s, dut_cout  input  1 each  DUT sum and carry responses.
REQ-008 busy  output  1  high in DRIVE or SAMPLE.
REQ-009 done  output  1  high in DONE.
REQ-010 pass  output  1  valid while done; high iff err_count==0.
REQ-011 err_count  output  4  saturating mismatch count for current sweep.
REQ-012 fail_valid  output  1  a mismatch has been recorded this sweep.
REQ-013 first_fail_vec  output  3  index {a,b,cin} of first mismatching vector; valid when fail_valid.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE: start=1 -> DRIVE with vec_idx=0, err_count=0, fail_valid=0, first_fail_vec=0, settle counter=SETTLE_CYCLES.
REQ-016 {a,b,cin} SHALL equal vec_idx (a = MSB) in DRIVE and SAMPLE; 0 in IDLE and DONE.
REQ-017 DRIVE: settle counter decrements each cycle; at 1 -> SAMPLE next cycle (DRIVE lasts exactly SETTLE_CYCLES cycles).
REQ-018 SAMPLE (one cycle): expected sum = a^b^cin, expected carry = majority(a,b,cin); mismatch if either DUT output differs.
REQ-019 On mismatch: err_count increments, saturating at 15; if fail_valid=0, set fail_valid=1 and first_fail_vec=vec_idx.
REQ-020 SAMPLE exit: vec_idx==7, or mismatch with STOP_ON_FAIL=1 -> DONE; else vec_idx+1 -> DRIVE with counter reloaded.
REQ-021 Full sweep latency: done SHALL rise 8*(SETTLE_CYCLES+1) cycles after the edge sampling start (16 for default).
REQ-022 DONE: outputs and results held; start=1 -> restart as in REQ-015 (results cleared on same edge).
REQ-023 start asserted while busy SHALL be ignored; no queuing.
REQ-024 DUT inputs outside SAMPLE SHALL have no effect.
REQ-025 vec_idx SHALL never wrap; 7 is terminal.

Reset
REQ-026 rst=1 at any clock edge, including mid-sweep, SHALL force IDLE, vec_idx=0, a=b=cin=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0.
REQ-027 rst SHALL take priority over start on the same edge.

Structure
REQ-028 Shared package fa_chk_pkg SHALL hold the state enum, NUM_VECTORS=8, VEC_W=3, ERR_W=4, ERR_MAX=15.
REQ-029 Expected-value logic SHALL be sub-module fa_ref_model (inputs a,b,cin; outputs exp_s, exp_cout), combinational.

Verification
REQ-030 Correct DUT, SETTLE_CYCLES=1, start pulse -> done at edge 16, pass=1, err_count=0, fail_valid=0.
REQ-031 DUT with carry stuck-at-0 -> done, pass=0, err_count=4, first_fail_vec=3.
REQ-032 STOP_ON_FAIL=1, sum inverted -> done after vector 0 (edge 2), err_count=1, first_fail_vec=0.
REQ-033 rst pulsed while vec_idx=4 -> next cycle IDLE, all outputs zero; later start gives a full clean sweep.
REQ-034 start held high throughout sweep -> no restart until DONE; then new sweep begins with results cleared.
REQ-035 SETTLE_CYCLES=3, correct DUT -> each vector held 3 cycles before sampling, done at edge 32, pass=1.
